// File: rtl/recip_gate_ctrl.sv
// Reciprocal-counter sequencer: edge-synchronous gate, coarse/event counting, fine-code merge.
// Result registered in the stop-edge cycle (valid one cycle later); held until ack, no backpressure upstream.
module recip_gate_ctrl #(
  parameter int COARSE_W = 29,
  parameter int TMO_W    = 24
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [31:0]           gate_cycles,
  input  logic                  sig_edge,
  input  logic [2:0]            fine_code,
  output logic                  busy,
  output logic                  result_valid,
  input  logic                  result_ack,
  output logic                  timeout,
  output logic                  overflow,
  output logic [COARSE_W-1:0]   coarse_count,
  output logic [31:0]           evt_count,
  output logic [COARSE_W+2:0]   final_count
);

  localparam int FW = COARSE_W + 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_GATE,
    S_WAIT,
    S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [31:0]           gate_len_q, gate_len_d;
  logic [31:0]           timer_q, timer_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;
  logic [COARSE_W-1:0]   coarse_q, coarse_d;
  logic [31:0]           evt_q, evt_d;
  logic [FW-1:0]         final_q, final_d;
  logic [2:0]            fine_start_q, fine_start_d;
  logic                  timeout_q, timeout_d;
  logic                  overflow_q, overflow_d;

  logic                  coarse_sat;
  logic [COARSE_W-1:0]   coarse_inc;
  logic [31:0]           evt_inc;
  logic [FW-1:0]         stop_final;

  always_comb begin
    state_d      = state_q;
    gate_len_d   = gate_len_q;
    timer_d      = timer_q;
    tmo_d        = tmo_q;
    coarse_d     = coarse_q;
    evt_d        = evt_q;
    final_d      = final_q;
    fine_start_d = fine_start_q;
    timeout_d    = timeout_q;
    overflow_d   = overflow_q;

    coarse_sat = (coarse_q == '1);
    coarse_inc = coarse_sat ? coarse_q : coarse_q + COARSE_W'(1);
    evt_inc    = sig_edge ? evt_q + 32'd1 : evt_q;
    // Uses the post-increment coarse so the stop-edge cycle itself is included.
    stop_final = {coarse_inc, 3'b000} + FW'(fine_start_q) - FW'(fine_code);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d      = S_ARM;
          gate_len_d   = (gate_cycles == 32'd0) ? 32'd1 : gate_cycles;
          tmo_d        = '0;
          coarse_d     = '0;
          evt_d        = '0;
          final_d      = '0;
          fine_start_d = '0;
          timeout_d    = 1'b0;
          overflow_d   = 1'b0;
        end
      end
      S_ARM: begin
        if (sig_edge) begin
          state_d      = S_GATE;
          fine_start_d = fine_code;
          coarse_d     = '0;
          evt_d        = '0;
          timer_d      = gate_len_q;
        end else if (tmo_q == '1) begin
          state_d   = S_DONE;
          timeout_d = 1'b1;
          final_d   = '0;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_GATE: begin
        coarse_d   = coarse_inc;
        overflow_d = overflow_q | coarse_sat;
        evt_d      = evt_inc;
        if (timer_q <= 32'd1) begin
          state_d = S_WAIT;
          tmo_d   = '0;
        end else begin
          timer_d = timer_q - 32'd1;
        end
      end
      S_WAIT: begin
        if (sig_edge) begin
          state_d    = S_DONE;
          coarse_d   = coarse_inc;
          overflow_d = overflow_q | coarse_sat;
          evt_d      = evt_inc;
          final_d    = stop_final;
        end else if (tmo_q == '1) begin
          // Counters freeze at their current values on timeout.
          state_d   = S_DONE;
          timeout_d = 1'b1;
          final_d   = '0;
        end else begin
          coarse_d   = coarse_inc;
          overflow_d = overflow_q | coarse_sat;
          tmo_d      = tmo_q + TMO_W'(1);
        end
      end
      S_DONE: begin
        if (result_ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (abort) begin
      state_d    = S_IDLE;
      coarse_d   = '0;
      evt_d      = '0;
      final_d    = '0;
      timeout_d  = 1'b0;
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      gate_len_q   <= '0;
      timer_q      <= '0;
      tmo_q        <= '0;
      coarse_q     <= '0;
      evt_q        <= '0;
      final_q      <= '0;
      fine_start_q <= '0;
      timeout_q    <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      gate_len_q   <= gate_len_d;
      timer_q      <= timer_d;
      tmo_q        <= tmo_d;
      coarse_q     <= coarse_d;
      evt_q        <= evt_d;
      final_q      <= final_d;
      fine_start_q <= fine_start_d;
      timeout_q    <= timeout_d;
      overflow_q   <= overflow_d;
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign result_valid = (state_q == S_DONE);
  assign timeout      = timeout_q;
  assign overflow     = overflow_q;
  assign coarse_count = coarse_q;
  assign evt_count    = evt_q;
  assign final_count  = final_q;

endmodule

// File: doc/recip_gate_ctrl.md
# recip_gate_ctrl

Measurement sequencer for the reciprocal frequency counter. It opens a gate that is synchronous to the measured signal. It counts reference-clock cycles and signal periods across that gate, and latches the sub-cycle fine interpolator codes at the start and stop edges. It then produces the combined time value: coarse×8 plus the fine correction. It sits between the input-edge detector / fine interpolator and the host register interface, and it owns the start/stop sequencing of one measurement.

## Interface
- COARSE_W, 29: coarse cycle-counter width; final time width is COARSE_W+3.
- TMO_W, 24: width of the no-edge timeout counter; timeout fires after 2^TMO_W−1 idle cycles.
- clk  in  1  reference clock; all logic is on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a measurement; honored only in IDLE.
- abort  in  1  returns to IDLE from any state; no result is produced.
- gate_cycles  in  32  minimum gate length in clk cycles; latched on accepted start; 0 is treated as 1.
- sig_edge  in  1  one-cycle pulse marking a registered rising edge of the measured signal.
- fine_code  in  3  eighths of a clk period between the signal edge and the clk edge that registered it; valid with sig_edge.
- busy  out  1  high in every state except IDLE.
- result_valid  out  1  high in DONE.
- result_ack  in  1  consumer accepts the result; honored only in DONE.
- timeout  out  1  DONE was reached by timeout; valid with result_valid.
- overflow  out  1  the coarse counter saturated; valid with result_valid.
- coarse_count  out  COARSE_W  clk cycles from the start-edge cycle to the stop-edge cycle.
- evt_count  out  32  signal edges after the start edge, including the stop edge.
- final_count  out  COARSE_W+3  coarse_count×8 + fine_start − fine_stop, computed modulo 2^(COARSE_W+3).

## Operation
- States:
  - IDLE → ARM on start.
  - ARM → GATE on sig_edge.
  - GATE → WAIT_STOP when the gate timer expires.
  - WAIT_STOP → DONE on sig_edge.
  - DONE → IDLE on result_ack.
  - ARM or WAIT_STOP → DONE on timeout.
  - Any state → IDLE on abort.
- ARM:
  - On sig_edge: latch fine_start=fine_code; clear coarse and evt; load the gate timer with max(gate_cycles,1).
  - Edges before this one are not counted.
- GATE and WAIT_STOP:
  - coarse increments every cycle and saturates at 2^COARSE_W−1; saturation sets the sticky overflow flag.
  - Each sig_edge increments evt; evt wraps at 2^32.
- GATE:
  - The timer decrements every cycle.
  - GATE lasts exactly max(gate_cycles,1) cycles.
  - An edge in the last GATE cycle is counted but does not stop the measurement.
- WAIT_STOP: the first sig_edge latches fine_stop=fine_code. final_count is then computed and registered in that same cycle.
- Timeout:
  - The timeout counter clears on entry to ARM/WAIT_STOP and on every sig_edge.
  - When it reaches 2^TMO_W−1: enter DONE with timeout=1 and final_count=0; coarse_count and evt_count hold their current values.
- Priority: abort > reset-free transitions. In DONE, start is ignored; if result_ack and start arrive together, ack is honored and start is dropped.
- Output values:
  - coarse_count, evt_count, final_count, timeout and overflow hold their values until the next accepted start, which clears them.
  - abort clears them as well.
- Reset: state IDLE; every output 0; all counters and latched fine codes 0.

## Timing
- start in cycle n → busy=1 in cycle n+1 (ARM).
- Start-edge cycle s → GATE occupies cycles s+1 .. s+G, where G=max(gate_cycles,1). WAIT_STOP begins at s+G+1.
- Stop-edge cycle e → coarse_count=e−s. result_valid=1 in cycle e+1 with all results stable.
- result_ack in cycle d → result_valid=0 and busy=0 in cycle d+1.
- abort in cycle a → IDLE and busy=0 in cycle a+1.
- Minimum coarse value is G+1. The fine correction spans −7..+7, so final_count ≥ 1 when there is no overflow.

## Test plan
- Basic measurement:
  - Stimulus: gate_cycles=10; edges at s, s+4, s+8, s+12; fine_start=5; fine_stop=2.
  - Required: result_valid at s+13; coarse_count=12; evt_count=3; final_count=99; timeout=0.
- Zero gate:
  - Stimulus: gate_cycles=0; edges every 3 cycles; fine codes 0 and 7.
  - Required: coarse_count=3; evt_count=1; final_count=17.
- Timeout:
  - Stimulus: TMO_W=4; start issued with no sig_edge.
  - Required: DONE 16 cycles after entering ARM; timeout=1; final_count=0.
  - Repeat the timeout check in WAIT_STOP.
- Abort:
  - Stimulus: abort mid-GATE.
  - Required: busy=0 the next cycle; result_valid never asserts; all outputs 0; a following start measures normally.
- Saturation:
  - Stimulus: COARSE_W=6; gate_cycles=100.
  - Required: coarse_count=63; overflow=1.
- Handshake:
  - Stimulus: result_ack and start in the same DONE cycle.
  - Required: IDLE, start dropped, and the results hold until the next accepted start.
  - Also: start while busy is ignored; edge timing against reset asserted mid-GATE gives all outputs 0 immediately.
